// File: rtl/fmul32.sv
// Two-stage pipelined binary32 multiplier: FMUL / FNMUL / FMULABS with four
// rounding modes, flush-to-zero subnormals and a single canonical quiet NaN.
module fmul32 #(
    parameter int DATA_W        = 32,
    parameter int OPERATION_NUM = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_W-1:0]                op1,
    input  logic [DATA_W-1:0]                op2,
    input  logic [$clog2(OPERATION_NUM)-1:0] opc,
    input  logic [1:0]                       r_mode,
    output logic [DATA_W-1:0]                result,
    output logic                             val
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        OP_FMUL    = 2'b00,
        OP_FNMUL   = 2'b01,
        OP_FMULABS = 2'b10,
        OP_RSVD    = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } rmode_t;

    logic [DATA_W-1:0]                op1_q, op2_q;
    logic [$clog2(OPERATION_NUM)-1:0] opc_q;
    logic [1:0]                       rmode_q;
    logic                             issue_q;
    logic [DATA_W-1:0]                result_q, result_d;
    logic                             val_q, val_d;

    logic        signA, signB, sign;
    logic [7:0]  expA, expB;
    logic [22:0] fracA, fracB;
    logic        nanA, nanB, infA, infB, zeroA, zeroB;
    logic [47:0] product;
    logic [22:0] mant;
    logic        guard, sticky, inexact, normInc, roundUp, carry;
    logic [23:0] rounded;
    logic [9:0]  expSum;
    logic [7:0]  expOut;
    logic [31:0] overflowRes;

    // Stage 1: capture operands and control; every non-reset cycle is an issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            op1_q   <= '0;
            op2_q   <= '0;
            opc_q   <= '0;
            rmode_q <= '0;
            issue_q <= 1'b0;
        end else begin
            op1_q   <= op1;
            op2_q   <= op2;
            opc_q   <= opc;
            rmode_q <= r_mode;
            issue_q <= 1'b1;
        end
    end

    always_comb begin
        signA = op1_q[31];
        signB = op2_q[31];
        expA  = op1_q[30:23];
        expB  = op2_q[30:23];
        fracA = op1_q[22:0];
        fracB = op2_q[22:0];

        nanA  = (expA == 8'hFF) && (fracA != 23'd0);
        nanB  = (expB == 8'hFF) && (fracB != 23'd0);
        infA  = (expA == 8'hFF) && (fracA == 23'd0);
        infB  = (expB == 8'hFF) && (fracB == 23'd0);
        zeroA = (expA == 8'h00);
        zeroB = (expB == 8'h00);

        case (opcode_t'(opc_q))
            OP_FNMUL:   sign = ~(signA ^ signB);
            OP_FMULABS: sign = 1'b0;
            default:    sign = signA ^ signB;
        endcase

        product = 48'({1'b1, fracA}) * 48'({1'b1, fracB});

        if (product[47]) begin
            normInc = 1'b1;
            mant    = product[46:24];
            guard   = product[23];
            sticky  = |product[22:0];
        end else begin
            normInc = 1'b0;
            mant    = product[45:23];
            guard   = product[22];
            sticky  = |product[21:0];
        end
        inexact = guard | sticky;

        case (rmode_t'(rmode_q))
            RM_RNE:  roundUp = guard & (sticky | mant[0]);
            RM_RTZ:  roundUp = 1'b0;
            RM_RUP:  roundUp = ~sign & inexact;
            default: roundUp = sign & inexact;
        endcase

        // A carry out leaves the fraction all-zero, so no explicit shift is needed.
        rounded = {1'b0, mant} + 24'(roundUp);
        carry   = rounded[23];

        // expSum holds the biased result exponent offset by +127, keeping it unsigned.
        expSum = 10'(expA) + 10'(expB) + 10'(normInc) + 10'(carry);
        expOut = 8'(expSum - 10'd127);

        case (rmode_t'(rmode_q))
            RM_RNE:  overflowRes = {sign, 8'hFF, 23'd0};
            RM_RTZ:  overflowRes = {sign, 8'hFE, 23'h7FFFFF};
            RM_RUP:  overflowRes = sign ? {1'b1, 8'hFE, 23'h7FFFFF} : {1'b0, 8'hFF, 23'd0};
            default: overflowRes = sign ? {1'b1, 8'hFF, 23'd0} : {1'b0, 8'hFE, 23'h7FFFFF};
        endcase

        result_d = '0;
        val_d    = 1'b0;
        if (issue_q && (opcode_t'(opc_q) != OP_RSVD)) begin
            val_d = 1'b1;
            if (nanA || nanB)
                result_d = QNAN;
            else if ((infA && zeroB) || (infB && zeroA))
                result_d = QNAN;
            else if (infA || infB)
                result_d = {sign, 8'hFF, 23'd0};
            else if (zeroA || zeroB)
                result_d = {sign, 31'd0};
            else if (expSum >= 10'd382)
                result_d = overflowRes;
            else if (expSum <= 10'd127)
                result_d = {sign, 31'd0};
            else
                result_d = {sign, expOut, rounded[22:0]};
        end
    end

    // Stage 2: registered result and its qualifier.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            val_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            val_q    <= val_d;
        end
    end

    assign result = result_q;
    assign val    = val_q;

endmodule

// File: tb/tb_fmul32.sv
// Self-checking bench for fmul32: directed cases with fixed expectations, then
// randomized traffic scored against an exact-integer rounding model.
module tb_fmul32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] op1, op2;
    logic [1:0]  opc, rMode;
    logic [31:0] result;
    logic        val;

    int errors = 0;
    int checks = 0;

    logic        known = 1'b0;
    logic        stageValid, stageVal, outVal;
    logic [31:0] stageRes, outRes;
    string       stageTag, outTag;

    always #5 clk = ~clk;

    fmul32 dut (
        .clk    (clk),
        .rst    (rst),
        .op1    (op1),
        .op2    (op2),
        .opc    (opc),
        .r_mode (rMode),
        .result (result),
        .val    (val)
    );

    function automatic logic [31:0] overflowValue(input bit s, input logic [1:0] rm);
        case (rm)
            2'd0:    return {s, 31'h7F800000};
            2'd1:    return {s, 31'h7F7FFFFF};
            2'd2:    return s ? 32'hFF7FFFFF : 32'h7F800000;
            default: return s ? 32'hFF800000 : 32'h7F7FFFFF;
        endcase
    endfunction

    // Exact product, then round by comparing the discarded remainder to one half-ulp.
    function automatic logic [31:0] refMul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op, input logic [1:0] rm);
        int     ea = int'(a[30:23]);
        int     eb = int'(b[30:23]);
        bit     s, aNan, bNan, aInf, bInf, aZero, bZero, up;
        longint p, q, rem, half;
        int     k, be;
        logic [63:0] qBits;
        if (op == 2'd3) return 32'h0;
        s = a[31] ^ b[31];
        if (op == 2'd1) s = !s;
        if (op == 2'd2) s = 1'b0;
        aNan  = (ea == 255) && (a[22:0] != 0);
        bNan  = (eb == 255) && (b[22:0] != 0);
        aInf  = (ea == 255) && (a[22:0] == 0);
        bInf  = (eb == 255) && (b[22:0] == 0);
        aZero = (ea == 0);
        bZero = (eb == 0);
        if (aNan || bNan) return 32'h7FC00000;
        if ((aInf && bZero) || (bInf && aZero)) return 32'h7FC00000;
        if (aInf || bInf) return {s, 8'hFF, 23'h0};
        if (aZero || bZero) return {s, 31'h0};
        p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        k = 0;
        while ((p >>> k) >= (longint'(1) <<< 24)) k++;
        q    = p >>> k;
        rem  = p - (q <<< k);
        half = longint'(1) <<< (k - 1);
        qBits = 64'(q);
        case (rm)
            2'd0:    up = (rem > half) || ((rem == half) && qBits[0]);
            2'd1:    up = 1'b0;
            2'd2:    up = !s && (rem != 0);
            default: up = s && (rem != 0);
        endcase
        q = q + longint'(up);
        if (q == (longint'(1) <<< 24)) begin
            q = q >>> 1;
            k++;
        end
        be = k + ea + eb - 150;
        if (be >= 255) return overflowValue(s, rm);
        if (be <= 0) return {s, 31'h0};
        qBits = 64'(q);
        return {s, be[7:0], qBits[22:0]};
    endfunction

    function automatic logic [31:0] randOperand();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 9))
            0: begin
                case ($urandom_range(0, 3))
                    0:       r[30:0] = 31'h0;
                    1:       r[30:0] = 31'h7F800000;
                    2:       r[30:23] = 8'hFF;
                    default: r[30:23] = 8'h00;
                endcase
            end
            1, 2: ;
            3: begin
                r[30:23] = 8'($urandom_range(100, 154));
                r[11:0]  = 12'h0;
            end
            default: r[30:23] = 8'($urandom_range(60, 194));
        endcase
        return r;
    endfunction

    task automatic checkOutput();
        if (known) begin
            checks++;
            assert (result === outRes) else begin
                errors++;
                $error("[TB] FAIL %s result: got %08h expected %08h", outTag, result, outRes);
            end
            checks++;
            assert (val === outVal) else begin
                errors++;
                $error("[TB] FAIL %s val: got %0b expected %0b", outTag, val, outVal);
            end
        end
    endtask

    // One cycle: check what the previous edges produced, drive new inputs, advance the model.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] op, input logic [1:0] rm,
                                 input bit resetIn, input bit useConst,
                                 input logic [31:0] constRes, input string tag);
        @(negedge clk);
        checkOutput();
        rst   = resetIn;
        op1   = a;
        op2   = b;
        opc   = op;
        rMode = rm;
        if (resetIn) begin
            known      = 1'b1;
            outRes     = 32'h0;
            outVal     = 1'b0;
            outTag     = "reset";
            stageValid = 1'b0;
            stageVal   = 1'b0;
            stageRes   = 32'h0;
            stageTag   = "reset";
        end else begin
            outRes     = stageValid ? stageRes : 32'h0;
            outVal     = stageValid && stageVal;
            outTag     = stageTag;
            stageValid = 1'b1;
            stageVal   = (op != 2'd3);
            stageRes   = useConst ? constRes : refMul(a, b, op, rm);
            stageTag   = tag;
        end
    endtask

    task automatic directed(input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] op, input logic [1:0] rm,
                            input logic [31:0] expected, input string tag);
        applyStimulus(a, b, op, rm, 1'b0, 1'b1, expected, tag);
    endtask

    initial begin
        rst = 1'b1; op1 = '0; op2 = '0; opc = '0; rMode = '0;
        applyStimulus(32'h0, 32'h0, 2'd0, 2'd0, 1'b1, 1'b0, 32'h0, "reset");
        applyStimulus(32'h0, 32'h0, 2'd0, 2'd0, 1'b1, 1'b0, 32'h0, "reset");

        directed(32'h3F800000, 32'h40000000, 2'd0, 2'd0, 32'h40000000, "fmul_1x2");
        directed(32'h3F800000, 32'h40000000, 2'd1, 2'd0, 32'hC0000000, "fnmul_1x2");
        directed(32'hBF800000, 32'h40000000, 2'd2, 2'd0, 32'h40000000, "fmulabs_m1x2");
        directed(32'h3F800001, 32'h3F800001, 2'd0, 2'd0, 32'h3F800002, "round_rne");
        directed(32'h3F800001, 32'h3F800001, 2'd0, 2'd1, 32'h3F800002, "round_rtz");
        directed(32'h3F800001, 32'h3F800001, 2'd0, 2'd2, 32'h3F800003, "round_rup");
        directed(32'h3F800001, 32'h3F800001, 2'd0, 2'd3, 32'h3F800002, "round_rdn");
        directed(32'h7F000000, 32'h7F000000, 2'd0, 2'd0, 32'h7F800000, "ovf_rne");
        directed(32'h7F000000, 32'h7F000000, 2'd0, 2'd1, 32'h7F7FFFFF, "ovf_rtz");
        directed(32'h7F000000, 32'h7F000000, 2'd1, 2'd3, 32'hFF800000, "ovf_fnmul_rdn");
        directed(32'h7F000000, 32'h7F000000, 2'd1, 2'd2, 32'hFF7FFFFF, "ovf_fnmul_rup");
        directed(32'h7F800000, 32'h00000000, 2'd0, 2'd0, 32'h7FC00000, "inf_x_zero");
        directed(32'h7FC00001, 32'h3F800000, 2'd0, 2'd0, 32'h7FC00000, "nan_in");
        directed(32'h7FC00001, 32'h3F800000, 2'd1, 2'd0, 32'h7FC00000, "nan_fnmul");
        directed(32'h00000001, 32'h3F800000, 2'd0, 2'd0, 32'h00000000, "subnormal_ftz");
        directed(32'h80000000, 32'h3F800000, 2'd0, 2'd0, 32'h80000000, "neg_zero");
        directed(32'h00000000, 32'h3F800000, 2'd1, 2'd0, 32'h80000000, "zero_fnmul");
        directed(32'hFF800000, 32'h40000000, 2'd0, 2'd0, 32'hFF800000, "neg_inf");
        directed(32'h3F800000, 32'h40000000, 2'd3, 2'd0, 32'h00000000, "reserved");
        directed(32'h3F800000, 32'h40000000, 2'd0, 2'd0, 32'h40000000, "b2b_fmul");
        directed(32'h3F800000, 32'h40000000, 2'd1, 2'd0, 32'hC0000000, "b2b_fnmul");
        directed(32'hBF800000, 32'h40000000, 2'd2, 2'd0, 32'h40000000, "b2b_fmulabs");
        directed(32'h3F800000, 32'h40000000, 2'd3, 2'd0, 32'h00000000, "b2b_rsvd");

        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                applyStimulus(randOperand(), randOperand(), 2'd0, 2'd0, 1'b1, 1'b0, 32'h0, "mid_reset");
            end else begin
                applyStimulus(randOperand(), randOperand(), 2'($urandom_range(0, 3)),
                              2'($urandom_range(0, 3)), 1'b0, 1'b0, 32'h0, "random");
            end
        end

        for (int i = 0; i < 3; i++)
            applyStimulus(32'h0, 32'h0, 2'd3, 2'd0, 1'b0, 1'b0, 32'h0, "drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
